// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM and its copy engine: default widths,
// engine state encoding and the forward-overlap test used to reject unsafe copies.
package dpram_pkg;

    localparam int DPRAM_ADDR_W = 10;
    localparam int DPRAM_DATA_W = 8;
    localparam int DPRAM_SUM_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // A forward copy is unsafe when the destination starts inside the not-yet-read
    // part of the source: 0 < (dst - src) mod depth < len.
    function automatic logic fwd_overlap(input logic [31:0] diff, input logic [31:0] len);
        return (diff != 32'd0) && (diff < len);
    endfunction

endpackage

// File: rtl/dpram.sv
// Dual-port RAM, synchronous read on both ports; each port writes when its enable is high.
module dpram #(
    parameter int ADDR_W = dpram_pkg::DPRAM_ADDR_W,
    parameter int DATA_W = dpram_pkg::DPRAM_DATA_W
) (
    input  logic              clk_i,
    input  logic              en1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] din1_i,
    output logic [DATA_W-1:0] dout1_o,
    input  logic              en2_i,
    input  logic [ADDR_W-1:0] addr2_i,
    input  logic [DATA_W-1:0] din2_i,
    output logic [DATA_W-1:0] dout2_o
);

    logic [DATA_W-1:0] mem_q [1 << ADDR_W];

    always_ff @(posedge clk_i) begin
        if (en1_i) begin
            mem_q[addr1_i] <= din1_i;
        end
        if (en2_i) begin
            mem_q[addr2_i] <= din2_i;
        end
        dout1_o <= mem_q[addr1_i];
        dout2_o <= mem_q[addr2_i];
    end

endmodule

// File: rtl/dpram_copy_engine.sv
// Block copy engine: streams len bytes from src_base to dst_base through a dual-port RAM
// (read on port 1, write on port 2) at one byte per clock, summing the bytes it writes.
module dpram_copy_engine
    import dpram_pkg::*;
#(
    parameter int ADDR_W = DPRAM_ADDR_W,
    parameter int DATA_W = DPRAM_DATA_W,
    parameter int SUM_W  = DPRAM_SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SUM_W-1:0]  checksum,
    output logic              ram_en1,
    output logic [ADDR_W-1:0] ram_addr1,
    input  logic [DATA_W-1:0] ram_dout1,
    output logic              ram_en2,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic [DATA_W-1:0] ram_din2,
    output state_e            dbg_state
);

    // Control protocol: start is a pulse looked at only in IDLE; an accepted request raises
    // busy on the next cycle, and exactly one of done or err pulses for every request that
    // is not aborted. start while busy is dropped, not queued.

    localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              en2_q, en2_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] diff;
    logic              hazard;

    assign diff   = dst_base - src_base;
    assign hazard = fwd_overlap(32'(diff), 32'(len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            sum_q    <= '0;
            en2_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            sum_q    <= sum_d;
            en2_q    <= en2_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        sum_d    = sum_q;
        en2_d    = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len > LEN_MAX) begin
                        err_d = 1'b1;
                    end else if (hazard) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        sum_d   = '0;
                        state_d = ST_FIN;
                    end else begin
                        rd_ptr_d = src_base;
                        wr_ptr_d = dst_base;
                        rd_cnt_d = len;
                        wr_cnt_d = len;
                        sum_d    = '0;
                        state_d  = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Read data arrives a cycle after its address, so a read issued at this
                // edge becomes a write one cycle later.
                if (rd_cnt_q != '0) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    rd_cnt_d = rd_cnt_q - CNT_ONE;
                    en2_d    = 1'b1;
                end
                if (en2_q) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    wr_cnt_d = wr_cnt_q - CNT_ONE;
                    sum_d    = sum_q + SUM_W'(ram_dout1);
                    if (wr_cnt_q == CNT_ONE) begin
                        state_d = ST_FIN;
                    end
                end
                // The write already on the port at this edge still lands and is counted.
                if (abort) begin
                    en2_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign checksum  = sum_q;
    assign ram_en1   = 1'b0;
    assign ram_addr1 = rd_ptr_q;
    assign ram_en2   = en2_q;
    assign ram_addr2 = wr_ptr_q;
    assign ram_din2  = ram_dout1;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Bench for dpram_copy_engine driving a real dpram; port-1 writes/reads are borrowed by the
// bench while the engine is idle to preload and read back memory.
module tb_dpram_copy_engine;
    import dpram_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int SW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, err;
    logic [SW-1:0] checksum;
    logic          ram_en1, ram_en2;
    logic [AW-1:0] ram_addr1, ram_addr2;
    logic [DW-1:0] ram_dout1, ram_din2, dout2;
    state_e        dbg_state;

    logic          tb_own = 1'b0;
    logic          tb_en1 = 1'b0;
    logic [AW-1:0] tb_addr1 = '0;
    logic [DW-1:0] tb_din1 = '0;
    logic          p1_en;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_din;

    assign p1_en   = tb_own ? tb_en1   : ram_en1;
    assign p1_addr = tb_own ? tb_addr1 : ram_addr1;
    assign p1_din  = tb_own ? tb_din1  : '0;

    dpram_copy_engine u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .err(err), .checksum(checksum),
        .ram_en1(ram_en1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1),
        .ram_en2(ram_en2), .ram_addr2(ram_addr2), .ram_din2(ram_din2),
        .dbg_state(dbg_state)
    );

    dpram u_ram (
        .clk_i(clk), .en1_i(p1_en), .addr1_i(p1_addr), .din1_i(p1_din), .dout1_o(ram_dout1),
        .en2_i(ram_en2), .addr2_i(ram_addr2), .din2_i(ram_din2), .dout2_o(dout2)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0]    model [1 << AW];
    logic [AW+DW-1:0] exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write seen on port 2 must match the next queued {addr, data}.
    always @(negedge clk) begin
        if (rst_n && ram_en2) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(ram_addr2), 32'(e[AW+DW-1:DW]));
                check("wr_data", 32'(ram_din2), 32'(e[DW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        tb_own   = 1'b1;
        tb_en1   = 1'b1;
        tb_addr1 = a;
        tb_din1  = d;
        model[a] = d;
    endtask

    task automatic mem_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        tb_own   = 1'b1;
        tb_en1   = 1'b0;
        tb_addr1 = a;
        @(negedge clk);
        d = ram_dout1;
    endtask

    task automatic verify_region(input logic [AW-1:0] base, input int n);
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = AW'(base + i);
            mem_read(a, d);
            check("mem_readback", 32'(d), 32'(model[a]));
        end
        tb_own = 1'b0;
    endtask

    task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW:0] n, input bit glitch);
        logic [AW-1:0] diff;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        bit            reject;
        logic [SW-1:0] sum;
        int            k;
        diff   = dst - src;
        reject = (n > 11'd1024) || ((diff != '0) && ({1'b0, diff} < n));
        @(negedge clk);
        src_base = src;
        dst_base = dst;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (reject) begin
            check("err_pulse", 32'(err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_done", 32'(done), 32'd0);
            @(negedge clk);
            check("err_clear", 32'(err), 32'd0);
            check("err_still_idle", 32'(busy), 32'd0);
        end else if (n == '0) begin
            check("zl_done", 32'(done), 32'd1);
            check("zl_busy", 32'(busy), 32'd0);
            check("zl_sum", 32'(checksum), 32'd0);
            check("zl_en2", 32'(ram_en2), 32'd0);
            @(negedge clk);
            check("zl_done_clear", 32'(done), 32'd0);
        end else begin
            sum = '0;
            for (int i = 0; i < int'(n); i++) begin
                s = AW'(src + i);
                d = AW'(dst + i);
                exp_q.push_back({d, model[s]});
                sum      = sum + SW'(model[s]);
                model[d] = model[s];
            end
            k = 0;
            while (busy && k < int'(n) + 8) begin
                if (k < int'(n)) check("rd_addr", 32'(ram_addr1), 32'(AW'(src + k)));
                start    = glitch && (k == 2);
                src_base = (glitch && k == 2) ? AW'(src + 7) : src;
                dst_base = (glitch && k == 2) ? AW'(dst + 50) : dst;
                @(negedge clk);
                k++;
            end
            start    = 1'b0;
            src_base = src;
            dst_base = dst;
            check("busy_cycles", 32'(k), 32'(n) + 32'd1);
            check("done_pulse", 32'(done), 32'd1);
            check("checksum", 32'(checksum), 32'(sum));
            check("en2_off", 32'(ram_en2), 32'd0);
            @(negedge clk);
            check("done_clear", 32'(done), 32'd0);
            check("checksum_hold", 32'(checksum), 32'(sum));
            check("queue_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_sum"}, 32'(checksum), 32'd0);
        check({tag, "_en1"}, 32'(ram_en1), 32'd0);
        check({tag, "_en2"}, 32'(ram_en2), 32'd0);
        check({tag, "_addr1"}, 32'(ram_addr1), 32'd0);
        check({tag, "_addr2"}, 32'(ram_addr2), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [SW-1:0] sum3;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Preload: mem[0..6] = 0,2,..,12, everything else random.
        for (int i = 0; i < (1 << AW); i++) begin
            mem_write(AW'(i), (i < 7) ? DW'(2 * i) : DW'($urandom_range(0, 255)));
        end
        @(negedge clk);
        tb_en1 = 1'b0;
        tb_own = 1'b0;

        // Basic copy: checksum of 0+2+..+12 is 42.
        run_copy(10'd0, 10'd20, 11'd7, 1'b0);
        check("basic_sum_42", 32'(checksum), 32'd42);
        verify_region(10'd20, 7);

        // Source wraps past the top of memory.
        run_copy(10'd1020, 10'd100, 11'd8, 1'b0);
        verify_region(10'd100, 8);

        // Forward overlap rejected, backward overlap accepted.
        run_copy(10'd10, 10'd12, 11'd5, 1'b0);
        run_copy(10'd12, 10'd10, 11'd5, 1'b0);
        verify_region(10'd9, 8);

        // Zero length and oversize length.
        run_copy(10'd5, 10'd6, 11'd0, 1'b0);
        run_copy(10'd0, 10'd500, 11'd1025, 1'b0);

        // In-place copy and a start pulse while busy.
        run_copy(10'd300, 10'd300, 11'd4, 1'b0);
        run_copy(10'd200, 10'd400, 11'd6, 1'b1);
        verify_region(10'd400, 6);
        verify_region(10'd450, 8);

        // Abort after the third write edge.
        sum3 = '0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({AW'(600 + i), model[500 + i]});
            sum3 = sum3 + SW'(model[500 + i]);
            model[600 + i] = model[500 + i];
        end
        @(negedge clk);
        src_base = 10'd500;
        dst_base = 10'd600;
        len      = 11'd10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_en2", 32'(ram_en2), 32'd0);
        check("abort_sum", 32'(checksum), 32'(sum3));
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("abort_sum_hold", 32'(checksum), 32'(sum3));
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        verify_region(10'd599, 12);

        // Reset mid-copy: only byte 0 has landed when reset asserts.
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({AW'(800 + i), model[700 + i]});
        end
        model[800] = model[700];
        @(negedge clk);
        src_base = 10'd700;
        dst_base = 10'd800;
        len      = 11'd10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        check("midreset_en2_hold", 32'(ram_en2), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        verify_region(10'd799, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
